// File: rtl/miic_pkg.sv
// miic_slave shared types: FSM states, bus ACK levels, R/W bit position.
// Imported by the filter and the target top.
package miic_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_MACK,
    ST_IGNORE
  } state_t;

  localparam logic ACK    = 1'b0;
  localparam logic NACK   = 1'b1;
  localparam int   RW_BIT = 0;

endpackage

// File: rtl/miic_filter.sv
// Pad synchroniser plus saturating-count glitch filter.
// Level flips after FILT_LEN equal samples; rise/fall pulse with it.
module miic_filter
  import miic_pkg::*;
#(
  parameter int FILT_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pad,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic [1:0] sync;
  logic [3:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= 2'b11;
      cnt  <= '0;
      lvl  <= 1'b1;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[0], pad};
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync[1] != lvl) begin
        if (cnt == 4'(FILT_LEN - 1)) begin
          lvl  <= sync[1];
          cnt  <= '0;
          rise <= sync[1];
          fall <= !sync[1];
        end else begin
          cnt <= cnt + 4'd1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/miic_slave.sv
// I2C target exposing an 8-bit register space with auto-increment.
// Filtered bus events drive a two-process FSM and a register datapath.
module miic_slave
  import miic_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h52,
  parameter int         FILT_LEN = 4,
  parameter int         SDA_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_o,
  output logic       sda_t,
  output logic [7:0] reg_addr,
  output logic       reg_wr_en,
  output logic [7:0] reg_wr_data,
  output logic       reg_rd_en,
  input  logic [7:0] reg_rd_data,
  output logic       busy,
  output logic       xfer_done
);

  logic scl, scl_rise, scl_fall;
  logic sda, sda_rise, sda_fall;
  logic start, stop;

  state_t     state, state_nxt;
  logic [2:0] bit_cnt;
  logic [7:0] shreg, tx, rx_byte;
  logic [7:0] hold_cnt;
  logic       hold_on, rw, rd_pend;
  logic       last_bit, drive_lo;
  logic       wr_go, rd_go, ld_ptr, match_go;

  miic_filter #(.FILT_LEN(FILT_LEN)) u_scl (
    .clk  (clk),
    .rst_n(rst_n),
    .pad  (scl_i),
    .lvl  (scl),
    .rise (scl_rise),
    .fall (scl_fall)
  );

  miic_filter #(.FILT_LEN(FILT_LEN)) u_sda (
    .clk  (clk),
    .rst_n(rst_n),
    .pad  (sda_i),
    .lvl  (sda),
    .rise (sda_rise),
    .fall (sda_fall)
  );

  assign sda_o    = 1'b0;
  assign start    = sda_fall & scl;
  assign stop     = sda_rise & scl;
  assign rx_byte  = {shreg[6:0], sda};
  assign last_bit = (bit_cnt == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wr_go     = 1'b0;
    rd_go     = 1'b0;
    ld_ptr    = 1'b0;
    match_go  = 1'b0;
    if (stop) begin
      state_nxt = ST_IDLE;
    end else if (start) begin
      state_nxt = ST_ADDR;
    end else if (scl_rise) begin
      unique case (state)
        ST_ADDR: if (last_bit) begin
          if (rx_byte[7:1] == DEV_ADDR) begin
            state_nxt = ST_ADDR_ACK;
            match_go  = 1'b1;
          end else begin
            state_nxt = ST_IGNORE;
          end
        end
        ST_ADDR_ACK: begin
          state_nxt = rw ? ST_RDATA : ST_PTR;
          rd_go     = rw;
        end
        ST_PTR: if (last_bit) begin
          state_nxt = ST_PTR_ACK;
          ld_ptr    = 1'b1;
        end
        ST_PTR_ACK: state_nxt = ST_WDATA;
        ST_WDATA: if (last_bit) begin
          state_nxt = ST_WDATA_ACK;
          wr_go     = 1'b1;
        end
        ST_WDATA_ACK: state_nxt = ST_WDATA;
        ST_RDATA: if (last_bit) state_nxt = ST_MACK;
        ST_MACK: begin
          state_nxt = (sda == ACK) ? ST_RDATA : ST_IGNORE;
          rd_go     = (sda == ACK);
        end
        default: ;
      endcase
    end
  end

  // SDA level the current bit slot wants once the hold time expires
  always_comb begin
    drive_lo = 1'b0;
    unique case (state)
      ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: drive_lo = 1'b1;
      ST_RDATA: drive_lo = !tx[7];
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sda_t       <= 1'b1;
      reg_addr    <= '0;
      reg_wr_en   <= 1'b0;
      reg_wr_data <= '0;
      reg_rd_en   <= 1'b0;
      busy        <= 1'b0;
      xfer_done   <= 1'b0;
      bit_cnt     <= '0;
      shreg       <= '0;
      tx          <= '0;
      hold_cnt    <= '0;
      hold_on     <= 1'b0;
      rw          <= 1'b0;
      rd_pend     <= 1'b0;
    end else begin
      reg_wr_en <= 1'b0;
      reg_rd_en <= 1'b0;
      xfer_done <= 1'b0;
      rd_pend   <= reg_rd_en;
      if (scl_rise) shreg <= rx_byte;
      if (start || stop)
        bit_cnt <= '0;
      else if (scl_rise)
        bit_cnt <= (state_nxt != state) ? 3'd0 : bit_cnt + 3'd1;
      if (match_go) begin
        rw   <= rx_byte[RW_BIT];
        busy <= 1'b1;
      end
      if (stop) begin
        busy      <= 1'b0;
        xfer_done <= busy;
      end
      if (wr_go) begin
        reg_wr_en   <= 1'b1;
        reg_wr_data <= rx_byte;
      end
      if (rd_go) reg_rd_en <= 1'b1;
      if (ld_ptr)
        reg_addr <= rx_byte;
      else if (reg_wr_en || rd_pend)
        reg_addr <= reg_addr + 8'd1;
      if (rd_pend)
        tx <= reg_rd_data;
      else if (scl_rise && state == ST_RDATA)
        tx <= {tx[6:0], 1'b0};
      if (start || stop) begin
        sda_t   <= 1'b1;
        hold_on <= 1'b0;
      end else if (scl_fall) begin
        hold_on  <= 1'b1;
        hold_cnt <= 8'(SDA_HOLD - 1);
      end else if (hold_on) begin
        if (hold_cnt == 8'd0) begin
          sda_t   <= drive_lo ? ACK : NACK;
          hold_on <= 1'b0;
        end else begin
          hold_cnt <= hold_cnt - 8'd1;
        end
      end
    end
  end

endmodule
